// File: rtl/flush_cache.sv
// -----------------------------------------------------------------------------
// flush_cache
//
// Copies a w x h block of 32-bit words from a small internal RAM (addressed
// {line, col}) to external memory over a Wishbone master port.  Each word
// takes a READ / LATCH / WRITE sequence.  The bus is locked (CYC/LOCK held)
// for the whole flush.  When both dimensions are non-zero, a flush takes
// 3*w*h+2 cycles from go to the flush_done pulse.  A zero dimension completes
// without any bus traffic.
//
// Optional feature macro: FLUSH_CACHE_ERR_EN
//   When defined, adds p_wb_ERR_I and flush_err.  An ERR during a write
//   aborts the flush.  flush_err and flush_done then pulse together.
//
// Ports
//   clk, RST            clock, asynchronous active-high reset
//   im_addr             external byte base address of the destination area
//   cache_w_I/cache_h_I block width / height in words
//   go / flush_done     start request / one-cycle completion pulse
//   ram_addr            internal RAM address {line, col}
//   ram_data_I          internal RAM data, valid one cycle after ram_addr
//   p_wb_*              Wishbone master (write-only, single-word cycles)
//   p_wb_ERR_I/flush_err  bus error input / error pulse (FLUSH_CACHE_ERR_EN)
// -----------------------------------------------------------------------------
module flush_cache #(
    parameter int ADDR_SIZE_W = 5,
    parameter int ADDR_SIZE_H = 1,
    parameter int DATA_SIZE   = 32
) (
    input  logic                             clk,
    input  logic                             RST,
    input  logic [31:0]                      im_addr,
    input  logic [ADDR_SIZE_W:0]             cache_w_I,
    input  logic [ADDR_SIZE_H:0]             cache_h_I,
    input  logic                             go,
    output logic                             flush_done,
    output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr,
    input  logic [DATA_SIZE-1:0]             ram_data_I,
    output logic [31:0]                      p_wb_DAT_O,
    input  logic                             p_wb_ACK_I,
    output logic                             p_wb_STB_O,
    output logic                             p_wb_CYC_O,
    output logic                             p_wb_LOCK_O,
    output logic                             p_wb_WE_O,
    output logic [3:0]                       p_wb_SEL_O,
    output logic [31:0]                      p_wb_ADR_O
`ifdef FLUSH_CACHE_ERR_EN
    ,
    input  logic                             p_wb_ERR_I,
    output logic                             flush_err
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Running word index wide enough for the largest w*h product.
    localparam int WORD_W = ADDR_SIZE_W + ADDR_SIZE_H + 2;
    localparam int PAD_W  = 32 - WORD_W - 2;

    localparam logic [ADDR_SIZE_W:0] ONE_COL  = {{ADDR_SIZE_W{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE_H:0] ONE_LINE = {{ADDR_SIZE_H{1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0]    ONE_WORD = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [2:0]             state_r;
    logic [31:0]            base_r;
    logic [ADDR_SIZE_W:0]   w_r;
    logic [ADDR_SIZE_H:0]   h_r;
    logic [ADDR_SIZE_W:0]   col_r;
    logic [ADDR_SIZE_H:0]   line_r;
    logic [WORD_W-1:0]      word_r;

    logic [ADDR_SIZE_W:0]   next_col_s;
    logic [ADDR_SIZE_H:0]   next_line_s;
    logic                   last_col_s;
    logic                   last_word_s;

    // Position of the word after the current one (column wraps into next line).
    always_comb begin
        last_col_s  = (col_r == (w_r - ONE_COL));
        last_word_s = last_col_s && (line_r == (h_r - ONE_LINE));
        next_col_s  = col_r + ONE_COL;
        next_line_s = line_r;
        if (last_col_s) begin
            next_col_s  = {(ADDR_SIZE_W+1){1'b0}};
            next_line_s = line_r + ONE_LINE;
        end else begin
            next_line_s = line_r;
        end
    end

    // Flush sequencer; every output is a register so reset clears it at once.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            base_r      <= 32'h0000_0000;
            w_r         <= {(ADDR_SIZE_W+1){1'b0}};
            h_r         <= {(ADDR_SIZE_H+1){1'b0}};
            col_r       <= {(ADDR_SIZE_W+1){1'b0}};
            line_r      <= {(ADDR_SIZE_H+1){1'b0}};
            word_r      <= {WORD_W{1'b0}};
            ram_addr    <= {(ADDR_SIZE_W+ADDR_SIZE_H){1'b0}};
            flush_done  <= 1'b0;
            p_wb_DAT_O  <= 32'h0000_0000;
            p_wb_ADR_O  <= 32'h0000_0000;
            p_wb_STB_O  <= 1'b0;
            p_wb_CYC_O  <= 1'b0;
            p_wb_LOCK_O <= 1'b0;
            p_wb_WE_O   <= 1'b0;
            p_wb_SEL_O  <= 4'h0;
`ifdef FLUSH_CACHE_ERR_EN
            flush_err   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    flush_done <= 1'b0;
`ifdef FLUSH_CACHE_ERR_EN
                    flush_err  <= 1'b0;
`endif
                    if (go) begin
                        if ((cache_w_I != {(ADDR_SIZE_W+1){1'b0}}) &&
                            (cache_h_I != {(ADDR_SIZE_H+1){1'b0}})) begin
                            base_r   <= im_addr;
                            w_r      <= cache_w_I;
                            h_r      <= cache_h_I;
                            col_r    <= {(ADDR_SIZE_W+1){1'b0}};
                            line_r   <= {(ADDR_SIZE_H+1){1'b0}};
                            word_r   <= {WORD_W{1'b0}};
                            ram_addr <= {(ADDR_SIZE_W+ADDR_SIZE_H){1'b0}};
                            state_r  <= READ;
                        end else begin
                            state_r  <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                // ram_addr was set on entry; RAM data appears during LATCH.
                READ: begin
                    state_r <= LATCH;
                end
                LATCH: begin
                    p_wb_DAT_O  <= ram_data_I;
                    // Word offset scaled to bytes; the add wraps modulo 2^32.
                    p_wb_ADR_O  <= base_r + {{PAD_W{1'b0}}, word_r, 2'b00};
                    p_wb_STB_O  <= 1'b1;
                    p_wb_CYC_O  <= 1'b1;
                    p_wb_LOCK_O <= 1'b1;
                    p_wb_WE_O   <= 1'b1;
                    p_wb_SEL_O  <= 4'hF;
                    state_r     <= WRITE;
                end
                WRITE: begin
`ifdef FLUSH_CACHE_ERR_EN
                    // ERR wins over a simultaneous ACK.
                    if (p_wb_ERR_I) begin
                        p_wb_STB_O  <= 1'b0;
                        p_wb_CYC_O  <= 1'b0;
                        p_wb_LOCK_O <= 1'b0;
                        p_wb_WE_O   <= 1'b0;
                        p_wb_SEL_O  <= 4'h0;
                        flush_err   <= 1'b1;
                        flush_done  <= 1'b1;
                        state_r     <= IDLE;
                    end else
`endif
                    if (p_wb_ACK_I) begin
                        p_wb_STB_O <= 1'b0;
                        p_wb_WE_O  <= 1'b0;
                        p_wb_SEL_O <= 4'h0;
                        word_r     <= word_r + ONE_WORD;
                        if (last_word_s) begin
                            p_wb_CYC_O  <= 1'b0;
                            p_wb_LOCK_O <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            col_r    <= next_col_s;
                            line_r   <= next_line_s;
                            ram_addr <= {next_line_s[ADDR_SIZE_H-1:0],
                                         next_col_s[ADDR_SIZE_W-1:0]};
                            state_r  <= READ;
                        end
                    end else begin
                        // Wait state: hold every bus signal.
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    flush_done <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flush_cache.sv
module tb_flush_cache;

    logic        clk;
    logic        RST;
    logic [31:0] im_addr;
    logic [5:0]  cache_w_I;
    logic [1:0]  cache_h_I;
    logic        go;
    logic        flush_done;
    logic [5:0]  ram_addr;
    logic [31:0] ram_data_I;
    logic [31:0] p_wb_DAT_O;
    logic        p_wb_ACK_I;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic        p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O;
`ifdef FLUSH_CACHE_ERR_EN
    logic        p_wb_ERR_I;
    logic        flush_err;
`endif

    flush_cache #(.ADDR_SIZE_W(5), .ADDR_SIZE_H(1), .DATA_SIZE(32)) dut (
        .clk(clk), .RST(RST), .im_addr(im_addr), .cache_w_I(cache_w_I),
        .cache_h_I(cache_h_I), .go(go), .flush_done(flush_done),
        .ram_addr(ram_addr), .ram_data_I(ram_data_I), .p_wb_DAT_O(p_wb_DAT_O),
        .p_wb_ACK_I(p_wb_ACK_I), .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O),
        .p_wb_LOCK_O(p_wb_LOCK_O), .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O),
        .p_wb_ADR_O(p_wb_ADR_O)
`ifdef FLUSH_CACHE_ERR_EN
        , .p_wb_ERR_I(p_wb_ERR_I), .flush_err(flush_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] key;
    int          wait_tbl[256];
    int          word_idx, wait_cnt, cyc_rises, bus_act, hold_viol;
    bit          hold_valid, cyc_prev, ack_noise, err_en;
    int          err_word, err_pulses, err_alone;
    logic [31:0] hold_adr, hold_dat;
    logic [31:0] wr_addr_q[$], wr_data_q[$], exp_addr_q[$], exp_data_q[$];

    // Internal RAM contents: a keyed scramble of the address.
    function automatic logic [31:0] ram_word(input logic [5:0] a);
        logic [31:0] x;
        x = {26'd0, a};
        return key ^ (x * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // RAM model: data follows the address by one cycle.
    always @(posedge clk) ram_data_I <= ram_word(ram_addr);

    // Wishbone slave with per-word wait states; records accepted writes.
    always @(negedge clk) begin
`ifdef FLUSH_CACHE_ERR_EN
        p_wb_ERR_I = 1'b0;
`endif
        if (p_wb_CYC_O && !cyc_prev) cyc_rises++;
        cyc_prev = p_wb_CYC_O;
        if (p_wb_STB_O || p_wb_CYC_O) bus_act++;
        if (p_wb_STB_O) begin
            if (!p_wb_CYC_O || !p_wb_LOCK_O || !p_wb_WE_O || p_wb_SEL_O != 4'hF) hold_viol++;
            if (hold_valid && (p_wb_ADR_O != hold_adr || p_wb_DAT_O != hold_dat)) hold_viol++;
            hold_adr = p_wb_ADR_O;
            hold_dat = p_wb_DAT_O;
            hold_valid = 1'b1;
            if (err_en && word_idx == err_word) begin
                p_wb_ACK_I = 1'b1;
`ifdef FLUSH_CACHE_ERR_EN
                p_wb_ERR_I = 1'b1;
`endif
                hold_valid = 1'b0;
            end else if (wait_cnt >= wait_tbl[word_idx & 255]) begin
                p_wb_ACK_I = 1'b1;
                wr_addr_q.push_back(p_wb_ADR_O);
                wr_data_q.push_back(p_wb_DAT_O);
                word_idx++;
                wait_cnt = 0;
                hold_valid = 1'b0;
            end else begin
                p_wb_ACK_I = 1'b0;
                wait_cnt++;
            end
        end else begin
            p_wb_ACK_I = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wait_cnt = 0;
            hold_valid = 1'b0;
        end
    end

    // Reference: the w*h words in row-major order, consecutive 4-byte addresses.
    task automatic build_expected(input logic [31:0] base, input int w, input int h);
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < w * h; i++) begin
            int line, col;
            line = i / w;
            col  = i % w;
            exp_addr_q.push_back(base + 32'(4 * i));
            exp_data_q.push_back(ram_word(6'((line % 2) * 32 + (col % 32))));
        end
    endtask

    function automatic int write_errors();
        int bad;
        bad = 0;
        if (wr_addr_q.size() != exp_addr_q.size()) bad++;
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) bad++;
        end
        return bad;
    endfunction

    // Start a flush and run until flush_done (plus a few cycles), bounded.
    task automatic run_flush(input logic [31:0] base, input int w, input int h,
                             input int repulse_at, output int cycles, output int done_cnt);
        int n;
        n = 0;
        cycles = -1;
        done_cnt = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        cyc_rises = 0; bus_act = 0; hold_viol = 0; word_idx = 0; wait_cnt = 0;
        err_pulses = 0; err_alone = 0;
        im_addr = base;
        cache_w_I = 6'(w);
        cache_h_I = 2'(h);
        go = 1'b1;
        while (n < ((cycles < 0) ? 4000 : cycles + 4)) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) go = 1'b0;
            if (n == repulse_at) begin
                go = 1'b1;
                im_addr = 32'hDEAD_0000;
                cache_w_I = 6'd1;
            end
            if (n == repulse_at + 1) go = 1'b0;
            if (flush_done) begin
                done_cnt++;
                if (cycles < 0) cycles = n;
            end
`ifdef FLUSH_CACHE_ERR_EN
            if (flush_err && flush_done) err_pulses++;
            if (flush_err && !flush_done) err_alone++;
`endif
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        go = 1'b0;
        im_addr = 32'h0;
        cache_w_I = 6'd0;
        cache_h_I = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O, p_wb_ADR_O,
             p_wb_DAT_O, ram_addr, flush_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got nonzero outputs (stb=%b cyc=%b adr=%h) need all 0",
                     p_wb_STB_O, p_wb_CYC_O, p_wb_ADR_O);
        end
        RST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({p_wb_STB_O, p_wb_CYC_O, flush_done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_after_reset: stb/cyc/done=%b need 000",
                     {p_wb_STB_O, p_wb_CYC_O, flush_done});
        end
    endtask

    task automatic test_basic_example();
        int cyc, dc, bad;
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
        build_expected(32'h0000_1000, 4, 2);
        run_flush(32'h0000_1000, 4, 2, 0, cyc, dc);
        bad = write_errors();
        tests_run++;
        if (cyc !== 26) begin tests_failed++; $display("FAIL basic_latency: got %0d need 26", cyc); end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_writes: %0d bad of %0d writes, need 0 bad of 8", bad, wr_addr_q.size());
        end
        tests_run++;
        if (wr_addr_q.size() != 8 || wr_addr_q[7] !== 32'h0000_101C) begin
            tests_failed++;
            $display("FAIL basic_last_addr: got %0d writes, need 8 ending at 0x101c", wr_addr_q.size());
        end
        tests_run++;
        if (dc !== 1 || cyc_rises !== 1) begin
            tests_failed++;
            $display("FAIL basic_done_cyc: done pulses %0d cyc rises %0d, need 1 and 1", dc, cyc_rises);
        end
    endtask

    task automatic test_wait_states();
        int cyc, dc, bad;
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
        wait_tbl[3] = 5;
        build_expected(32'h0000_1000, 4, 2);
        run_flush(32'h0000_1000, 4, 2, 0, cyc, dc);
        bad = write_errors();
        tests_run++;
        if (hold_viol !== 0) begin tests_failed++; $display("FAIL wait_hold: %0d bus changes during wait, need 0", hold_viol); end
        tests_run++;
        if (cyc_rises !== 1 || bad !== 0 || wr_addr_q.size() != 8) begin
            tests_failed++;
            $display("FAIL wait_writes: cyc rises %0d bad %0d count %0d, need 1 0 8", cyc_rises, bad, wr_addr_q.size());
        end
        tests_run++;
        if (cyc !== 31) begin tests_failed++; $display("FAIL wait_latency: got %0d need 31", cyc); end
        wait_tbl[3] = 0;
    endtask

    task automatic test_zero_dim();
        int cyc, dc;
        run_flush(32'h0000_5000, 0, 3, 0, cyc, dc);
        tests_run++;
        if (cyc !== 2 || dc !== 1 || bus_act !== 0 || wr_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_w: latency %0d done %0d bus cycles %0d, need 2 1 0", cyc, dc, bus_act);
        end
        run_flush(32'h0000_5000, 5, 0, 0, cyc, dc);
        tests_run++;
        if (cyc !== 2 || dc !== 1 || bus_act !== 0) begin
            tests_failed++;
            $display("FAIL zero_h: latency %0d done %0d bus cycles %0d, need 2 1 0", cyc, dc, bus_act);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc, dc, n;
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
        wait_tbl[2] = 20;
        wr_addr_q.delete(); wr_data_q.delete();
        word_idx = 0; wait_cnt = 0;
        im_addr = 32'h0000_1000; cache_w_I = 6'd4; cache_h_I = 2'd2; go = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            go = 1'b0;
            n++;
        end while (!(p_wb_STB_O && word_idx == 2) && n < 100);
        tests_run++;
        if (n >= 100) begin tests_failed++; $display("FAIL rst_reach_word2: timeout after %0d cycles", n); end
        #2;
        RST = 1'b1;
        #1;
        tests_run++;
        if ({p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O, p_wb_ADR_O,
             p_wb_DAT_O, ram_addr, flush_done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_write: stb=%b cyc=%b adr=%h need all outputs 0",
                     p_wb_STB_O, p_wb_CYC_O, p_wb_ADR_O);
        end
        wait_tbl[2] = 0;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        build_expected(32'h0000_3000, 1, 1);
        run_flush(32'h0000_3000, 1, 1, 0, cyc, dc);
        tests_run++;
        if (write_errors() !== 0 || cyc !== 5 || dc !== 1) begin
            tests_failed++;
            $display("FAIL rst_then_single: writes %0d latency %0d done %0d, need 1 5 1", wr_addr_q.size(), cyc, dc);
        end
    endtask

    task automatic test_repulse();
        int cyc, dc;
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
        build_expected(32'h0000_2000, 3, 2);
        run_flush(32'h0000_2000, 3, 2, 5, cyc, dc);
        tests_run++;
        if (write_errors() !== 0 || wr_addr_q.size() != 6) begin
            tests_failed++;
            $display("FAIL repulse_writes: got %0d writes, need 6 unchanged", wr_addr_q.size());
        end
        tests_run++;
        if (cyc !== 20 || dc !== 1) begin
            tests_failed++;
            $display("FAIL repulse_done: latency %0d done %0d, need 20 1", cyc, dc);
        end
    endtask

    task automatic test_random();
        int cyc, dc, w, h, extra, bad;
        logic [31:0] base;
        ack_noise = 1'b1;
        for (int it = 0; it < 8; it++) begin
            base = (it == 0) ? 32'hFFFF_FFF0 : $urandom;
            w = (it == 0) ? 8 : $urandom_range(1, 32);
            h = (it == 0) ? 1 : $urandom_range(1, 2);
            extra = 0;
            for (int i = 0; i < 256; i++) begin
                wait_tbl[i] = (i < w * h) ? $urandom_range(0, 3) : 0;
                extra += wait_tbl[i];
            end
            build_expected(base, w, h);
            run_flush(base, w, h, 0, cyc, dc);
            bad = write_errors();
            tests_run++;
            if (bad !== 0 || hold_viol !== 0) begin
                tests_failed++;
                $display("FAIL rand_writes[%0d]: w=%0d h=%0d bad %0d hold %0d, need 0 0", it, w, h, bad, hold_viol);
            end
            tests_run++;
            if (cyc !== 3 * w * h + 2 + extra || dc !== 1 || cyc_rises !== 1) begin
                tests_failed++;
                $display("FAIL rand_timing[%0d]: latency %0d done %0d rises %0d, need %0d 1 1",
                         it, cyc, dc, cyc_rises, 3 * w * h + 2 + extra);
            end
        end
        ack_noise = 1'b0;
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
    endtask

`ifdef FLUSH_CACHE_ERR_EN
    task automatic test_err();
        int cyc, dc;
        err_en = 1'b1;
        err_word = 1;
        run_flush(32'h0000_4000, 4, 1, 0, cyc, dc);
        err_en = 1'b0;
        tests_run++;
        if (dc !== 1 || err_pulses !== 1 || err_alone !== 0) begin
            tests_failed++;
            $display("FAIL err_pulse: done %0d joint err %0d lone err %0d, need 1 1 0", dc, err_pulses, err_alone);
        end
        tests_run++;
        if (wr_addr_q.size() != 1 || p_wb_CYC_O !== 1'b0 || p_wb_STB_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_release: writes %0d cyc %b, need 1 0", wr_addr_q.size(), p_wb_CYC_O);
        end
    endtask
`endif

    initial begin
        key = $urandom;
        ack_noise = 1'b0; err_en = 1'b0; err_word = 0;
        cyc_prev = 1'b0; hold_valid = 1'b0;
        p_wb_ACK_I = 1'b0;
`ifdef FLUSH_CACHE_ERR_EN
        p_wb_ERR_I = 1'b0;
`endif
        for (int i = 0; i < 256; i++) wait_tbl[i] = 0;
        test_reset();
        test_basic_example();
        test_wait_states();
        test_zero_dim();
        test_reset_mid_write();
        test_repulse();
        test_random();
`ifdef FLUSH_CACHE_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flush_cache.md
FLUSH_CACHE -- requirements
Module: flush_cache

Interface
REQ-001 SHALL have parameter ADDR_SIZE_W, default 5, meaning the column-index width of the internal RAM address.
REQ-002 SHALL have parameter ADDR_SIZE_H, default 1, meaning the line-index width of the internal RAM address.
REQ-003 SHALL have parameter DATA_SIZE, default 32, meaning the internal RAM word width (fixed 32 for this block).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port im_addr, input, 32 bits: external RAM byte base address of the destination area.
REQ-007 SHALL have ports cache_w_I, input, ADDR_SIZE_W+1 bits, and cache_h_I, input, ADDR_SIZE_H+1 bits: block width and height in words.
REQ-008 SHALL have ports go, input, 1 bit (start request), and flush_done, output, 1 bit (completion pulse).
REQ-009 SHALL have port ram_addr, output, ADDR_SIZE_W+ADDR_SIZE_H bits, formatted {line, col}, and port ram_data_I, input, DATA_SIZE bits, valid one cycle after ram_addr.
REQ-010 SHALL have Wishbone master ports: p_wb_DAT_O out 32; p_wb_ACK_I in 1; p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O out 1; p_wb_SEL_O out 4; p_wb_ADR_O out 32.

Function
REQ-011 SHALL implement states IDLE, READ, LATCH, WRITE, DONE.
REQ-012 In IDLE, SHALL sample go; on go=1 with cache_w_I and cache_h_I both non-zero, SHALL latch im_addr, cache_w_I, and cache_h_I, clear line/col to 0, and enter READ.
REQ-013 On go=1 with either dimension zero, SHALL go directly to DONE with no bus activity.
REQ-014 In READ, ram_addr SHALL equal {line, col}; the next state SHALL be LATCH.
REQ-015 In LATCH, SHALL register ram_data_I into p_wb_DAT_O and p_wb_ADR_O = base + 4*(line*w + col) (32-bit, wraps modulo 2^32), assert STB/CYC/WE/LOCK with SEL=4'hF, and enter WRITE.
REQ-016 In WRITE, STB, ADR, DAT_O, and SEL SHALL hold stable until ACK_I=1 is sampled; an ACK sampled while STB=0 SHALL be ignored.
REQ-017 On ACK in WRITE, SHALL drop STB and advance col; when col reaches w-1 it SHALL wrap col to 0 and increment line.
REQ-018 After the ACK for the last word (line=h-1, col=w-1), SHALL drop CYC and LOCK and enter DONE; otherwise SHALL enter READ.
REQ-019 CYC and LOCK SHALL stay high continuously from the first STB through the last ACK of a flush.
REQ-020 The minimum per-word time with zero-wait ACK SHALL be 3 cycles; total flush time SHALL be 3*w*h+2 cycles from go to the flush_done pulse.
REQ-021 In DONE, flush_done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-022 go SHALL be ignored outside IDLE, and changes to im_addr, cache_w_I, or cache_h_I mid-flush SHALL have no effect.

Reset
REQ-023 RST=1 SHALL immediately force IDLE and set all outputs to 0 (STB, CYC, LOCK, WE, SEL, ADR, DAT_O, ram_addr, flush_done), including in the middle of a bus cycle.
REQ-024 The first rising edge after RST falls SHALL evaluate IDLE with go.

Configuration
REQ-025 With FLUSH_CACHE_ERR_EN defined, SHALL add input p_wb_ERR_I (1 bit) and output flush_err (1 bit, reset 0).
REQ-026 With FLUSH_CACHE_ERR_EN defined, ERR sampled in WRITE SHALL drop STB/CYC/LOCK, pulse flush_err and flush_done together for one cycle, and return to IDLE; ERR and ACK sampled in the same cycle SHALL be treated as ERR.
REQ-027 Without FLUSH_CACHE_ERR_EN, those ports SHALL not exist and only the ACK behaviour applies.

Verification
REQ-028 w=4, h=2, base 0x1000, zero-wait ACK -> 8 writes to 0x1000..0x101C in order, ram_addr sequence {0,0}..{0,3},{1,0}..{1,3}, flush_done at cycle 26.
REQ-029 ACK delayed 5 cycles on word 3 -> ADR, DAT_O, and STB held for all 5 cycles; CYC never drops; word count stays 8.
REQ-030 go with w=0 -> no STB/CYC at any point, flush_done 2 cycles after go.
REQ-031 RST asserted while in WRITE of word 2 -> all outputs 0 in the same cycle; a later go with w=1, h=1 -> a single write to the new base.
REQ-032 go re-pulsed mid-flush and im_addr changed -> no restart, addresses unchanged, exactly one flush_done.
REQ-033 With FLUSH_CACHE_ERR_EN, ERR on word 2 of 4 -> bus released, flush_err and flush_done pulse together, no further writes.
